// File: rtl/exu_issue.sv
// exu_issue: issue stage in front of the multi-cycle RV32M/RV32F exu.
// Decodes one op, issues it, waits for completion or timeout, hands to wb.
//
// Ports:
//   clk, rstn              clock, synchronous active-low reset
//   req_valid/req_ready    op handshake from the core (ready only in IDLE)
//   req_inst/src1/src2/rd  raw instruction, operands, destination index
//   ex_sig                 20-bit one-hot op select to the exu
//   ex_src1/ex_src2        operands to the exu
//   ex_out_valid           1-cycle issue pulse
//   ex_result/exception    exu completion data, valid on ex_in_valid
//   ex_in_valid            1-cycle exu completion pulse
//   wb_valid/wb_ready      writeback handshake
//   wb_rd/fp/data/exc      writeback entry
//   wb_illegal/wb_timeout  undecodable op / exu never answered
module exu_issue #(
    parameter int TIMEOUT = 100
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_inst,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic [4:0]  req_rd,
    output logic [19:0] ex_sig,
    output logic [31:0] ex_src1,
    output logic [31:0] ex_src2,
    output logic        ex_out_valid,
    input  logic [31:0] ex_result,
    input  logic [2:0]  ex_exception,
    input  logic        ex_in_valid,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic        wb_fp,
    output logic [31:0] wb_data,
    output logic [2:0]  wb_exception,
    output logic        wb_illegal,
    output logic        wb_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // WAIT lasts at most TIMEOUT cycles: counter values 0..TIMEOUT-1
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        is_m;
    logic        is_f;
    logic [19:0] dec_sig;
    logic        dec_fp;
    logic        dec_legal;
    logic        accept;
    logic        unused_inst;

    assign opcode = req_inst[6:0];
    assign funct3 = req_inst[14:12];
    assign funct7 = req_inst[31:25];

    // register specifiers are irrelevant to op selection
    assign unused_inst = ^{req_inst[24:15], req_inst[11:7]};

    assign is_m = (opcode == 7'b0110011) && (funct7 == 7'b0000001);
    assign is_f = (opcode == 7'b1010011);

    always_comb begin
        dec_sig = '0;
        dec_fp  = 1'b0;
        unique case (1'b1)
            is_m: begin
                dec_sig = 20'd1 << funct3;
            end
            is_f && (funct7 == 7'b0000000): begin
                dec_sig[8] = 1'b1;
                dec_fp     = 1'b1;
            end
            is_f && (funct7 == 7'b0000100): begin
                dec_sig[9] = 1'b1;
                dec_fp     = 1'b1;
            end
            is_f && (funct7 == 7'b0001000): begin
                dec_sig[10] = 1'b1;
                dec_fp      = 1'b1;
            end
            is_f && (funct7 == 7'b0001100): begin
                dec_sig[11] = 1'b1;
                dec_fp      = 1'b1;
            end
            is_f && (funct7 == 7'b1010000) && (funct3 == 3'b010): begin
                dec_sig[12] = 1'b1;
            end
            is_f && (funct7 == 7'b1010000) && (funct3 == 3'b001): begin
                dec_sig[13] = 1'b1;
            end
            is_f && (funct7 == 7'b1010000) && (funct3 == 3'b000): begin
                dec_sig[14] = 1'b1;
            end
            is_f && (funct7 == 7'b0010000) && (funct3 == 3'b000): begin
                dec_sig[15] = 1'b1;
                dec_fp      = 1'b1;
            end
            is_f && (funct7 == 7'b0010000) && (funct3 == 3'b001): begin
                dec_sig[16] = 1'b1;
                dec_fp      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dec_legal = |dec_sig;
    assign accept    = req_valid && (state == IDLE);

    assign req_ready    = (state == IDLE);
    assign ex_out_valid = (state == ISSUE);
    assign wb_valid     = (state == RESP);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = dec_legal ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (ex_in_valid || (cnt == CNT_LAST)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (wb_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt          <= '0;
            ex_sig       <= '0;
            ex_src1      <= '0;
            ex_src2      <= '0;
            wb_rd        <= '0;
            wb_fp        <= 1'b0;
            wb_data      <= '0;
            wb_exception <= '0;
            wb_illegal   <= 1'b0;
            wb_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ex_sig       <= dec_sig;
                        ex_src1      <= req_src1;
                        ex_src2      <= req_src2;
                        wb_rd        <= req_rd;
                        wb_fp        <= dec_fp;
                        wb_data      <= '0;
                        wb_exception <= '0;
                        wb_illegal   <= ~dec_legal;
                        wb_timeout   <= 1'b0;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    // a response in the last cycle beats the timeout
                    if (ex_in_valid) begin
                        wb_data      <= ex_result;
                        wb_exception <= ex_exception;
                    end else if (cnt == CNT_LAST) begin
                        wb_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
